// File: rtl/all_ones_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : all_ones_check_arbiter
// Brief   : Round-robin shares one registered all-ones evaluator between
//           N_REQ valid/ready requesters; returns tagged results, counts hits.
// Revision: 1.0 - initial release
// ============================================================================
module all_ones_check_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_all_ones,
  output logic [DATA_W-1:0]       rsp_mask,
  output logic                    busy,
  output logic [CNT_W-1:0]        hit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_word;
  logic [ID_W-1:0]   r_id;
  logic              r_all_ones;
  logic [CNT_W-1:0]  r_hit_count;

  logic [DATA_W-1:0] w_words [N_REQ];
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic              w_accept;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_words[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Search starts at the round-robin pointer and wraps; first valid wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_found;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EVAL;
      EVAL:    w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_word      <= '0;
      r_id        <= '0;
      r_all_ones  <= 1'b0;
      r_hit_count <= '0;
    end else begin
      if (w_accept) begin
        r_word   <= w_words[w_winner];
        r_id     <= w_winner;
        r_rr_ptr <= (w_winner == ID_W'(N_REQ-1)) ? '0 : w_winner + 1'b1;
      end
      if (r_state == EVAL) begin
        r_all_ones <= &r_word;
      end
      // Count only delivered hits; hold at all-ones once saturated.
      if ((r_state == RESP) && rsp_ready && r_all_ones && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
    end
  end

  assign rsp_valid    = (r_state == RESP);
  assign rsp_id       = r_id;
  assign rsp_all_ones = r_all_ones;
  assign rsp_mask     = {DATA_W{r_all_ones}};
  assign busy         = (r_state != IDLE);
  assign hit_count    = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_all_ones_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_all_ones_check_arbiter
// Brief   : Randomized bench with a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_all_ones_check_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rsp_ready;

  logic [N_REQ-1:0]  req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_all_ones;
  logic [DATA_W-1:0] rsp_mask;
  logic              busy;
  logic [15:0]       hit_count;

  logic [N_REQ-1:0]  req_ready_s;
  logic              rsp_valid_s;
  logic [ID_W-1:0]   rsp_id_s;
  logic              rsp_all_ones_s;
  logic [DATA_W-1:0] rsp_mask_s;
  logic              busy_s;
  logic [1:0]        hit_count_s;

  all_ones_check_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_all_ones(rsp_all_ones), .rsp_mask(rsp_mask),
    .busy(busy), .hit_count(hit_count)
  );

  // Same stimulus, narrow counter: exercises saturation.
  all_ones_check_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_s), .rsp_all_ones(rsp_all_ones_s), .rsp_mask(rsp_mask_s),
    .busy(busy_s), .hit_count(hit_count_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding words with their accept cycle.
  typedef struct {
    int           id;
    logic [7:0]   data;
    int           acc;
  } txn_t;

  txn_t             m_q[$];
  int               m_rr    = 0;
  int               m_hits  = 0;
  int               m_hits2 = 0;
  int               cyc     = 0;
  logic [N_REQ-1:0] accepted_mask = '0;

  bit log_en = 1'b0;
  int glog[$];
  int gcyc[$];

  always @(negedge clk) begin
    int               win;
    logic [N_REQ-1:0] exp_ready;
    logic             exp_valid;
    txn_t             t;
    if (!rst_n) begin
      m_q.delete();
      m_rr          = 0;
      m_hits        = 0;
      m_hits2       = 0;
      accepted_mask = '0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_hit_count", 32'(hit_count), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
    end else begin
      win       = -1;
      exp_ready = '0;
      exp_valid = 1'b0;
      if (m_q.size() == 0) begin
        for (int k = 0; k < N_REQ; k++) begin
          int i;
          i = (m_rr + k) % N_REQ;
          if (win < 0 && req_valid[i]) win = i;
        end
        if (win >= 0) exp_ready = N_REQ'(1 << win);
      end else begin
        exp_valid = (cyc >= m_q[0].acc + 2);
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_q.size() != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("hit_count_sat", 32'(hit_count_s), 32'(m_hits2));
      if (exp_valid) begin
        t = m_q[0];
        chk("rsp_id", 32'(rsp_id), 32'(t.id));
        chk("rsp_all_ones", 32'(rsp_all_ones), 32'(t.data == 8'hFF));
        chk("rsp_mask", 32'(rsp_mask), (t.data == 8'hFF) ? 32'hFF : 32'h00);
      end
      if (log_en && req_ready != '0) begin
        glog.push_back($clog2(req_ready));
        gcyc.push_back(cyc);
      end
      accepted_mask = '0;
      if (win >= 0) begin
        t.id   = win;
        t.data = req_data[win*DATA_W +: DATA_W];
        t.acc  = cyc;
        m_q.push_back(t);
        m_rr          = (win + 1) % N_REQ;
        accepted_mask = N_REQ'(1 << win);
      end else if (exp_valid && rsp_ready) begin
        if (m_q[0].data == 8'hFF) begin
          if (m_hits < 65535) m_hits++;
          if (m_hits2 < 3) m_hits2++;
        end
        void'(m_q.pop_front());
      end
    end
    cyc++;
  end

  logic       pend  [N_REQ];
  logic [7:0] wdata [N_REQ];

  task automatic apply();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]                 = pend[i];
      req_data[i*DATA_W +: DATA_W] = wdata[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N_REQ; i++) begin
      pend[i]  = 1'b0;
      wdata[i] = 8'h00;
    end
  endtask

  // One cycle per iteration: retire accepted words, maybe raise/withdraw requests.
  task automatic run(input int n, input int p_new, input int p_ff, input int p_rdy);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (accepted_mask[i]) pend[i] = 1'b0;
        else if (pend[i] && p_new > 0 && p_new < 100 && $urandom_range(0, 99) < 2) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 99) < p_new) begin
          pend[i]  = 1'b1;
          wdata[i] = ($urandom_range(0, 99) < p_ff) ? 8'hFF : 8'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 99) < p_rdy);
      apply();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_pend();
    rsp_ready = 1'b0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    clear_pend();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single all-ones word from requester 0
    pend[0] = 1'b1; wdata[0] = 8'hFF; rsp_ready = 1'b1; apply();
    run(5, 0, 0, 100);

    // non-all-ones word from requester 1
    pend[1] = 1'b1; wdata[1] = 8'hFE; apply();
    run(5, 0, 0, 100);

    // all requesters continuously valid: rotation and spacing
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      pend[i]  = 1'b1;
      wdata[i] = 8'($urandom);
    end
    rsp_ready = 1'b1;
    apply();
    log_en = 1'b1;
    run(16, 100, 50, 100);
    log_en = 1'b0;
    if (glog.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("grant_order", 32'(glog[k]), 32'(exp_order[k]));
      for (int k = 1; k < 5; k++) chk("accept_gap", 32'(gcyc[k] - gcyc[k-1]), 3);
    end else begin
      chk("grant_count", 32'(glog.size()), 5);
    end
    clear_pend(); apply();
    run(6, 0, 0, 100);

    // consumer stalls for 5 RESP cycles, accepts on the 6th
    pend[2] = 1'b1; wdata[2] = 8'hFF;
    pend[0] = 1'b1; wdata[0] = 8'h0F;
    rsp_ready = 1'b0;
    apply();
    run(2, 0, 0, 0);
    run(4, 0, 0, 0);
    run(1, 0, 0, 100);
    run(8, 0, 0, 100);

    // reset while evaluating an all-ones word
    pend[3] = 1'b1; wdata[3] = 8'hFF; rsp_ready = 1'b1; apply();
    @(posedge clk);
    #1;
    chk("eval_busy", 32'(busy), 1);
    rst_n = 1'b0;
    clear_pend();
    apply();
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_hit_count", 32'(hit_count), 0);
    chk("async_req_ready", 32'(req_ready), 0);
    chk("async_rsp_id", 32'(rsp_id), 0);
    chk("async_rsp_all_ones", 32'(rsp_all_ones), 0);
    chk("async_rsp_mask", 32'(rsp_mask), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend[0] = 1'b1; wdata[0] = 8'hFF;
    pend[2] = 1'b1; wdata[2] = 8'hFF;
    apply();
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    run(10, 0, 0, 100);

    // randomized traffic, plenty of all-ones words
    run(3000, 30, 50, 60);
    chk("sat_cntw2", 32'(hit_count_s), 3);

    clear_pend(); apply();
    run(10, 0, 0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
